// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM array controller.
package sram_pkg;

  localparam int DATA_W = 32;
  localparam int NBYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    DONE
  } state_t;

  // Expands byte enables into a bit mask over the data word.
  function automatic logic [DATA_W-1:0] be_mask(input logic [NBYTES-1:0] be);
    be_mask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      be_mask[8*i +: 8] = {8{be[i]}};
    end
  endfunction

endpackage

// File: rtl/sram_wl_decoder.sv
// One-hot address-to-wordline decoder; all-zero when disabled or out of range.
module sram_wl_decoder #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0]    addr,
  input  logic             enable,
  output logic [DEPTH-1:0] wl
);

  always_comb begin
    wl = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (enable && (32'(addr) == 32'(i))) begin
        wl[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Request/response controller sequencing SETUP/PULSE/DONE accesses on an SRAM array.
// Optional macro SRAM_CTRL_ERR_EN adds an rsp_err output flagging out-of-range addresses.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [NBYTES-1:0] req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [DEPTH-1:0]  wl,
  output logic [NBYTES-1:0] byte_sel,
  output logic [DATA_W-1:0] datain,
  input  logic [DATA_W-1:0] dataout,
  output logic              read_pulse,
  output logic              write_pulse
`ifdef SRAM_CTRL_ERR_EN
  ,
  output logic              rsp_err
`endif
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q;
  logic                we_q;
  logic [NBYTES-1:0]   be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                in_range;
  logic                hit;
  logic                active;
  logic                accept;

  assign accept   = req_valid && (state_q == IDLE);
  assign in_range = (32'(addr_q) < DEPTH_U);
  // A zero byte-enable or out-of-range address walks the FSM without touching the array.
  assign hit      = in_range && (be_q != '0);
  assign active   = (state_q == SETUP) || (state_q == PULSE);

  sram_wl_decoder #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_decoder (
    .addr   (addr_q),
    .enable (active && hit),
    .wl     (wl)
  );

  assign byte_sel    = active ? be_q : '0;
  assign datain      = (active && we_q) ? wdata_q : '0;
  assign write_pulse = (state_q == PULSE) && hit && we_q;
  assign read_pulse  = (state_q == PULSE) && hit && !we_q;
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == DONE);
  assign rsp_rdata   = rdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = SETUP;
      SETUP:   state_d = PULSE;
      PULSE:   state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        be_q    <= req_be;
        wdata_q <= req_wdata;
      end
      // Read data is masked to the enabled bytes; writes and skipped accesses return zero.
      if (state_q == PULSE) begin
        rdata_q <= (hit && !we_q) ? (dataout & be_mask(be_q)) : '0;
      end
    end
  end

`ifdef SRAM_CTRL_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == PULSE) begin
      err_q <= !in_range;
    end
  end

  assign rsp_err = err_q;
`endif

endmodule
